dtw_axil_master: RTL

DTW_AXIL_MASTER -- requirements
Module: dtw_axil_master

---
 rtl/dtw_axil_master.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dtw_axil_master.sv
// dtw_axil_master: one-outstanding AXI4-Lite master behind a valid/ready command/response port.
// Define AXIL_MASTER_TIMEOUT_EN to add a watchdog that aborts a stalled transfer with resp 2'b11.
module dtw_axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst,
  // command / response port
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  // AXI4-Lite master
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [DATA_WIDTH-1:0] i_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_wvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_bready;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  // A channel is finished once its valid is already down or is being accepted this cycle.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             w_wait_state;
  logic             w_advance;
  logic             w_timeout;

  always_comb begin
    // NOTE: default assignment first so every path drives w_advance and no latch is inferred.
    w_advance = 1'b0;
    case (r_state)
      S_WR_ADDR_DATA: w_advance = w_aw_done && w_w_done;
      S_WR_RESP:      w_advance = i_bvalid;
      S_RD_ADDR:      w_advance = i_arready;
      S_RD_DATA:      w_advance = i_rvalid;
      default:        w_advance = 1'b0;
    endcase
  end

  assign w_wait_state = (r_state != S_IDLE) && (r_state != S_RSP);
  assign w_timeout    = w_wait_state && !w_advance && (r_to_cnt == CNT_LAST);

  // Cycles spent in the current waiting state; cleared on every state change.
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      r_to_cnt <= '0;
    end else if (!w_wait_state || w_advance || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (w_timeout) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= RESP_TIMEOUT;
        r_rsp_valid <= 1'b1;
        r_state     <= S_RSP;
      end else begin
`else
      begin
`endif
        case (r_state)
          S_IDLE: begin
            r_cmd_ready <= 1'b1;
            if (r_cmd_ready && i_cmd_valid) begin
              r_cmd_ready <= 1'b0;
              if (i_cmd_write) begin
                r_awaddr  <= i_cmd_addr;
                r_wdata   <= i_cmd_wdata;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_state   <= S_WR_ADDR_DATA;
              end else begin
                r_araddr  <= i_cmd_addr;
                r_arvalid <= 1'b1;
                r_state   <= S_RD_ADDR;
              end
            end
          end

          S_WR_ADDR_DATA: begin
            if (r_awvalid && i_awready) r_awvalid <= 1'b0;
            if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              r_bready <= 1'b1;
              r_state  <= S_WR_RESP;
            end
          end

          S_WR_RESP: begin
            if (i_bvalid) begin
              r_bready    <= 1'b0;
              r_rsp_resp  <= i_bresp;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RSP;
            end
          end

          S_RD_ADDR: begin
            if (i_arready) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= S_RD_DATA;
            end
          end

          S_RD_DATA: begin
            if (i_rvalid) begin
              r_rready    <= 1'b0;
              r_rsp_rdata <= i_rdata;
              r_rsp_resp  <= i_rresp;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RSP;
            end
          end

          S_RSP: begin
            if (i_rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_awvalid   = r_awvalid;
  assign o_awaddr    = r_awaddr;
  assign o_wvalid    = r_wvalid;
  assign o_wdata     = r_wdata;
  assign o_bready    = r_bready;
  assign o_arvalid   = r_arvalid;
  assign o_araddr    = r_araddr;
  assign o_rready    = r_rready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;

endmodule
